// File: rtl/gray_morph_pkg.sv
// gray_morph_pkg: morphology mode codes, pipeline latency and width-generic pixel min/max helpers.
package gray_morph_pkg;

    localparam logic [1:0] MORPH_PASS     = 2'b00;
    localparam logic [1:0] MORPH_ERODE    = 2'b01;
    localparam logic [1:0] MORPH_DILATE   = 2'b10;
    localparam logic [1:0] MORPH_GRADIENT = 2'b11;

    localparam int MORPH_LATENCY = 3;
    localparam int PX_MAX_W      = 32;

    // Operands arrive zero-extended to PX_MAX_W; w masks them back to the real pixel width.
    function automatic logic [PX_MAX_W-1:0] px_mask(input int w);
        return (w >= PX_MAX_W) ? '1 : ((PX_MAX_W'(1) << w) - PX_MAX_W'(1));
    endfunction

    function automatic logic [PX_MAX_W-1:0] px_min(input int w, input logic [PX_MAX_W-1:0] a,
                                                   input logic [PX_MAX_W-1:0] b);
        logic [PX_MAX_W-1:0] am, bm;
        am = a & px_mask(w);
        bm = b & px_mask(w);
        return (am < bm) ? am : bm;
    endfunction

    function automatic logic [PX_MAX_W-1:0] px_max(input int w, input logic [PX_MAX_W-1:0] a,
                                                   input logic [PX_MAX_W-1:0] b);
        logic [PX_MAX_W-1:0] am, bm;
        am = a & px_mask(w);
        bm = b & px_mask(w);
        return (am > bm) ? am : bm;
    endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// gray_line_buffer: two-line shift store; each entry holds {row r-2, row r-1} for one column.
module gray_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_HDISP  = 640,
    parameter int AW         = $clog2(IMG_HDISP)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] tap1,
    output logic [DATA_WIDTH-1:0] tap2
);
    logic [2*DATA_WIDTH-1:0] mem [IMG_HDISP];
    logic [2*DATA_WIDTH-1:0] rd;

    // Read-before-write: the old r-1 moves to the r-2 half, din becomes the new r-1.
    always_ff @(posedge clk)
        if (shift_en) mem[addr] <= {mem[addr][DATA_WIDTH-1:0], din};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)        rd <= '0;
        else if (shift_en) rd <= mem[addr];

    assign tap1 = rd[DATA_WIDTH-1:0];
    assign tap2 = rd[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/gray_morph_filter.sv
// gray_morph_filter: 3x3 grayscale erode/dilate/gradient/pass on a vsync/href stream, 3 clk latency.
// Build option MORPH_BORDER_PASS_EN: border slots carry the raw centre pixel instead of 0.
module gray_morph_filter
    import gray_morph_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter logic [10:0] IMG_HDISP  = 11'd640,
    parameter logic [10:0] IMG_VDISP  = 11'd480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic [DATA_WIDTH-1:0] per_img_Gray,
    input  logic [1:0]            morph_mode,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic [DATA_WIDTH-1:0] post_img_Gray,
    output logic [1:0]            mode_active
);
    localparam int AW = $clog2(int'(IMG_HDISP));

    typedef logic [DATA_WIDTH-1:0] px_t;
    typedef px_t [2:0]             col_t;

    function automatic px_t min2(input px_t a, input px_t b);
        return px_t'(px_min(DATA_WIDTH, PX_MAX_W'(a), PX_MAX_W'(b)));
    endfunction
    function automatic px_t max2(input px_t a, input px_t b);
        return px_t'(px_max(DATA_WIDTH, PX_MAX_W'(a), PX_MAX_W'(b)));
    endfunction
    function automatic px_t min3(input col_t c);
        return min2(min2(c[0], c[1]), c[2]);
    endfunction
    function automatic px_t max3(input col_t c);
        return max2(max2(c[0], c[1]), c[2]);
    endfunction

    logic        vsync_q, href_q, frame_ok;
    logic [10:0] col_cnt, row_cnt;
    logic        vsync_rise, href_fall, in_line, border_in;

    assign vsync_rise = per_frame_vsync & ~vsync_q;
    assign href_fall  = ~per_frame_href & href_q;
    assign in_line    = col_cnt < IMG_HDISP;
    // frame_ok keeps everything border until a vsync rise has been seen since reset.
    assign border_in  = ~frame_ok | (row_cnt < 11'd2) | (col_cnt < 11'd2) | ~in_line;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            frame_ok    <= 1'b0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            mode_active <= MORPH_PASS;
        end else begin
            vsync_q <= per_frame_vsync;
            href_q  <= per_frame_href;
            if (vsync_rise) begin
                mode_active <= morph_mode;
                frame_ok    <= 1'b1;
            end
            if (per_frame_href) begin
                if (col_cnt != IMG_HDISP) col_cnt <= col_cnt + 11'd1;
            end else if (href_q) begin
                col_cnt <= '0;
            end
            if (vsync_rise)                          row_cnt <= '0;
            else if (href_fall && row_cnt != IMG_VDISP) row_cnt <= row_cnt + 11'd1;
        end

    px_t tap1, tap2;

    gray_line_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .IMG_HDISP (int'(IMG_HDISP)),
        .AW        (AW)
    ) u_lbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_en(per_frame_href & in_line),
        .addr    (col_cnt[AW-1:0]),
        .din     (per_img_Gray),
        .tap1    (tap1),
        .tap2    (tap2)
    );

    // Stage 1: window columns; index [2]=row r, [1]=r-1, [0]=r-2.
    px_t  pix_q;
    col_t col0, col1, col2;
    col_t [2:0] win;

    assign col0 = {pix_q, tap1, tap2};
    assign win  = {col2, col1, col0};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pix_q <= '0;
            col1  <= '0;
            col2  <= '0;
        end else if (per_frame_href) begin
            pix_q <= per_img_Gray;
            col1  <= col0;
            col2  <= col1;
        end

    logic [MORPH_LATENCY-1:0] vs_pipe, hs_pipe;
    logic [MORPH_LATENCY-2:0] bd_pipe;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vs_pipe <= '0;
            hs_pipe <= '0;
            bd_pipe <= '0;
        end else begin
            vs_pipe <= {vs_pipe[MORPH_LATENCY-2:0], per_frame_vsync};
            hs_pipe <= {hs_pipe[MORPH_LATENCY-2:0], per_frame_href};
            bd_pipe <= {bd_pipe[MORPH_LATENCY-3:0], border_in};
        end

    // Stage 2: per-column vertical min/max.
    col_t cmin, cmax;
    px_t  s2_centre;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cmin      <= '0;
            cmax      <= '0;
            s2_centre <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                cmin[k] <= min3(win[k]);
                cmax[k] <= max3(win[k]);
            end
            s2_centre <= col1[1];
        end

    // Stage 3: horizontal min/max, op select, border mux.
    px_t mn, mx, op_val, border_val, result;

`ifdef MORPH_BORDER_PASS_EN
    assign border_val = s2_centre;
`else
    assign border_val = '0;
`endif

    always_comb begin
        mn     = min3(cmin);
        mx     = max3(cmax);
        op_val = s2_centre;
        case (mode_active)
            MORPH_ERODE:    op_val = mn;
            MORPH_DILATE:   op_val = mx;
            MORPH_GRADIENT: op_val = mx - mn;
            default:        op_val = s2_centre;
        endcase
        result = bd_pipe[MORPH_LATENCY-2] ? border_val : op_val;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) post_img_Gray <= '0;
        else        post_img_Gray <= hs_pipe[MORPH_LATENCY-2] ? result : '0;

    assign post_frame_vsync = vs_pipe[MORPH_LATENCY-1];
    assign post_frame_href  = hs_pipe[MORPH_LATENCY-1];

endmodule

// File: tb/tb_gray_morph_filter.sv
// Bench for gray_morph_filter on an 8x6 image: spec-level 3x3 model checked every cycle plus literal pins.
module tb_gray_morph_filter;
    localparam int H = 8;
    localparam int V = 6;

    logic       clk = 1'b0, rst_n = 1'b0, vs = 1'b0, hs = 1'b0;
    logic [7:0] px = '0;
    logic [1:0] mode = '0;
    logic       pvs, phs;
    logic [7:0] ppx;
    logic [1:0] mact;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    gray_morph_filter #(.DATA_WIDTH(8), .IMG_HDISP(11'd8), .IMG_VDISP(11'd6)) dut (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hs), .per_img_Gray(px),
        .morph_mode(mode), .post_frame_vsync(pvs), .post_frame_href(phs), .post_img_Gray(ppx),
        .mode_active(mact));

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
        end
    endtask

    // Reference: pixels stored per frame position; each output slot computed from its 3x3 neighbourhood.
    typedef struct {logic v; logic h; logic [7:0] p; logic cp;} exp_t;
    exp_t expq[$];
    exp_t cur = '{1'b0, 1'b0, 8'd0, 1'b1};
    int   mframe[0:V][0:H];
    int   m_col, m_row;
    logic m_vs, m_hs, m_fv;
    logic [1:0] m_mode = '0;

    function automatic logic [7:0] ref_px(input int r, input int c, input logic [1:0] md);
        int mn = 255, mx = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
                if (mframe[r-2+dr][c-2+dc] < mn) mn = mframe[r-2+dr][c-2+dc];
                if (mframe[r-2+dr][c-2+dc] > mx) mx = mframe[r-2+dr][c-2+dc];
            end
        case (md)
            2'd0:    return 8'(mframe[r-1][c-1]);
            2'd1:    return 8'(mn);
            2'd2:    return 8'(mx);
            default: return 8'(mx - mn);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int r, c;
        logic bord, vr;
        if (!rst_n) begin
            m_col = 0; m_row = 0; m_vs = 0; m_hs = 0; m_fv = 0; m_mode = 2'd0;
            expq.delete();
            expq.push_back('{1'b0, 1'b0, 8'd0, 1'b1});
            expq.push_back('{1'b0, 1'b0, 8'd0, 1'b1});
            cur = '{1'b0, 1'b0, 8'd0, 1'b1};
        end else begin
            e  = '{vs, hs, 8'd0, 1'b1};
            vr = vs && !m_vs;
            if (vr) begin m_mode = mode; m_fv = 1; end
            if (hs) begin
                r = m_row; c = m_col;
                if (c < H) mframe[r][c] = int'(px);
                bord = !m_fv || r < 2 || c < 2 || c >= H;
                if (!bord) e.p = ref_px(r, c, m_mode);
`ifdef MORPH_BORDER_PASS_EN
                else if (m_fv && r >= 1 && c >= 1 && c < H) e.p = 8'(mframe[r-1][c-1]);
                else e.cp = 1'b0;
`endif
                if (m_col < H) m_col++;
            end else if (m_hs) begin
                m_col = 0;
            end
            if (vr) m_row = 0;
            else if (!hs && m_hs && m_row < V) m_row++;
            m_vs = vs; m_hs = hs;
            expq.push_back(e);
            cur = expq.pop_front();
        end
    end

    // Per-cycle compare plus capture of the output frame for literal pins.
    int   outimg[0:V][0:H];
    int   orow = 0, ocol = 0;
    logic ph_q = 1'b0, pv_q = 1'b0;

    always @(negedge clk) begin
        chk("post_vsync", int'(pvs), int'(cur.v));
        chk("post_href", int'(phs), int'(cur.h));
        if (cur.cp) chk("post_pixel", int'(ppx), int'(cur.p));
        chk("mode_active", int'(mact), int'(m_mode));
        if (pvs && !pv_q) orow = 0;
        if (phs) begin
            if (ocol <= H) outimg[orow][ocol] = int'(ppx);
            ocol++;
        end else if (ph_q) begin
            ocol = 0;
            if (orow < V) orow++;
        end
        ph_q = phs; pv_q = pvs;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] pat(input int kind, input int r, input int c);
        case (kind)
            1:       return (r == 3 && c == 3) ? 8'd200 : 8'd50;
            2:       return ((r + c) % 2 == 1) ? 8'd255 : 8'd0;
            default: return 8'($urandom);
        endcase
    endfunction

    // kind: 0 random, 1 flat 50 with 200 at (3,3), 2 checkerboard. -1 disables long_line/mid_mode/rst_line.
    task automatic frame(input logic [1:0] md, input int kind, input int long_line,
                         input int mid_mode, input int rst_line);
        int len;
        mode = md; vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        repeat (4) tick();
        for (int r = 0; r < V; r++) begin
            len = (r == long_line) ? H + 1 : H;
            for (int c = 0; c < len; c++) begin
                hs = 1'b1; px = pat(kind, r, c);
                if (r == rst_line && c == 4) begin
                    #1 rst_n = 1'b0;
                    #1;
                    chk("rst_vsync", int'(pvs), 0);
                    chk("rst_href", int'(phs), 0);
                    chk("rst_pixel", int'(ppx), 0);
                    chk("rst_mode", int'(mact), 0);
                    hs = 1'b0; px = '0;
                    repeat (2) @(posedge clk);
                    #1 rst_n = 1'b1;
                    break;
                end
                tick();
            end
            hs = 1'b0; px = '0;
            if (r == 2 && mid_mode >= 0) mode = 2'(mid_mode);
            repeat ($urandom_range(3, 20)) tick();
        end
        repeat (6) tick();
    endtask

    int bexp;

    initial begin
`ifdef MORPH_BORDER_PASS_EN
        bexp = 50;
`else
        bexp = 0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();

        frame(2'd1, 1, -1, -1, -1);
        chk("erode_44", outimg[4][4], 50);
        chk("erode_33", outimg[3][3], 50);

        frame(2'd2, 1, -1, -1, -1);
        chk("dilate_44", outimg[4][4], 200);
        chk("dilate_33", outimg[3][3], 200);
        chk("dilate_55", outimg[5][5], 200);
        chk("dilate_56", outimg[5][6], 50);
        chk("dilate_22", outimg[2][2], 50);
        chk("border_15", outimg[1][5], bexp);
        chk("border_41", outimg[4][1], bexp);

        frame(2'd3, 1, -1, -1, -1);
        chk("grad_44", outimg[4][4], 150);
        chk("grad_35", outimg[3][5], 150);
        chk("grad_26", outimg[2][6], 0);

        frame(2'd1, 0, -1, 2, -1);
        chk("mode_hold", int'(mact), 1);
        frame(2'd2, 0, -1, -1, -1);
        chk("mode_new", int'(mact), 2);

        frame(2'd3, 0, 3, -1, -1);
`ifndef MORPH_BORDER_PASS_EN
        chk("longline_border", outimg[3][8], 0);
`endif

        frame(2'd1, 2, -1, -1, -1);
        chk("checker_erode", outimg[3][4], 0);
        frame(2'd2, 2, -1, -1, -1);
        chk("checker_dilate", outimg[3][4], 255);

        frame(2'd2, 0, -1, -1, 2);
        for (int i = 0; i < 6; i++) frame(2'($urandom_range(0, 3)), 0, (i == 2) ? 4 : -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
